// File: rtl/instr_buffer.sv
// Instruction buffer between fetch and dispatch: circular FIFO of fetched packets.
// Latency: a packet enqueued on edge N appears at the head no earlier than cycle N+1 (no bypass).
// Backpressure: ib_full stalls fetch (pushes while full are dropped); pops while empty are ignored.

package instr_buffer_pkg;

  // Canonical RISC-V NOP (addi x0, x0, 0), shown to dispatch when the buffer is empty.
  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] inst;
    logic        valid;
    logic [31:0] PC;
    logic [31:0] NPC;
  } IF_IB_PACKET;

endpackage

module instr_buffer
  import instr_buffer_pkg::*;
#(
  parameter int IB_DEPTH = 8
) (
  input  logic                      clock,
  input  logic                      reset,
  input  IF_IB_PACKET               if_ib_packet,
  input  logic                      dp_pop,
  input  logic                      squash,
  output IF_IB_PACKET               ib_dp_packet,
  output logic                      ib_full,
  output logic                      ib_empty,
  output logic [$clog2(IB_DEPTH):0] ib_count
);

  localparam int PTR_W = $clog2(IB_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  IF_IB_PACKET            entries [IB_DEPTH];
  logic [PTR_W-1:0]       head;
  logic [PTR_W-1:0]       tail;
  logic                   push_ok;
  logic                   pop_ok;

  // Advance a pointer with an explicit wrap so no entry is ever skipped.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(IB_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Flags come from the registered count only, so they never depend on same-cycle inputs.
  assign ib_full  = (ib_count == CNT_W'(IB_DEPTH));
  assign ib_empty = (ib_count == '0);

  // Qualify requests against the registered flags: a full buffer drops the push even
  // if a pop frees a slot this cycle, and an empty buffer ignores the pop.
  always_comb begin
    push_ok = if_ib_packet.valid && !ib_full;
    pop_ok  = dp_pop && !ib_empty;
  end

  // Pointer and occupancy update; reset beats squash, squash beats push/pop.
  always_ff @(posedge clock) begin
    if (!reset) begin
      head     <= '0;
      tail     <= '0;
      ib_count <= '0;
    end else if (squash) begin
      head     <= '0;
      tail     <= '0;
      ib_count <= '0;
    end else begin
      if (push_ok) tail <= ptr_inc(tail);
      if (pop_ok)  head <= ptr_inc(head);
      case ({push_ok, pop_ok})
        2'b10:   ib_count <= ib_count + CNT_W'(1);
        2'b01:   ib_count <= ib_count - CNT_W'(1);
        default: ib_count <= ib_count;
      endcase
    end
  end

  // Entry storage: write the accepted packet at the tail, forcing its valid bit.
  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int i = 0; i < IB_DEPTH; i++) begin
        entries[i].valid <= 1'b0;
      end
    end else if (!squash && push_ok) begin
      entries[tail]       <= if_ib_packet;
      entries[tail].valid <= 1'b1;
    end
  end

  // Head presentation straight from registered state; an empty buffer shows a NOP bubble.
  always_comb begin
    ib_dp_packet      = '0;
    ib_dp_packet.inst = NOP_INST;
    if (!ib_empty) begin
      ib_dp_packet = entries[head];
    end
  end

endmodule

// File: tb/tb_instr_buffer.sv
// Randomized plus directed bench for instr_buffer against a queue-based reference model.
// Latency: outputs are sampled 1 time unit after each rising edge and just before it.
// Backpressure: the model drops pushes when full and ignores pops when empty.

module tb_instr_buffer;
  import instr_buffer_pkg::*;

  localparam int DEPTH = 8;

  logic        clock;
  logic        reset;
  IF_IB_PACKET if_ib_packet;
  logic        dp_pop;
  logic        squash;
  IF_IB_PACKET ib_dp_packet;
  logic        ib_full;
  logic        ib_empty;
  logic [3:0]  ib_count;

  int checks = 0;
  int errors = 0;

  IF_IB_PACKET model_q [$];

  instr_buffer #(.IB_DEPTH(DEPTH)) dut (
    .clock        (clock),
    .reset        (reset),
    .if_ib_packet (if_ib_packet),
    .dp_pop       (dp_pop),
    .squash       (squash),
    .ib_dp_packet (ib_dp_packet),
    .ib_full      (ib_full),
    .ib_empty     (ib_empty),
    .ib_count     (ib_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Single comparison point: counts every check and reports mismatches.
  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic IF_IB_PACKET nop_pkt();
    IF_IB_PACKET p;
    p      = '0;
    p.inst = NOP_INST;
    return p;
  endfunction

  function automatic IF_IB_PACKET model_head();
    if (model_q.size() == 0) return nop_pkt();
    return model_q[0];
  endfunction

  // Compare all DUT outputs against the model's current view.
  task automatic check_outputs(input string when_tag);
    check({when_tag, " count"}, 128'(ib_count), 128'(model_q.size()));
    check({when_tag, " full"},  128'(ib_full),  128'(model_q.size() == DEPTH));
    check({when_tag, " empty"}, 128'(ib_empty), 128'(model_q.size() == 0));
    check({when_tag, " head"},  128'(ib_dp_packet), 128'(model_head()));
  endtask

  // One clock: drive inputs, confirm outputs do not react combinationally,
  // clock the DUT and the model together, then compare.
  task automatic step(input logic vld, input logic [31:0] pc, input logic pop,
                      input logic sq, input logic rst);
    IF_IB_PACKET pkt;
    logic        was_full;
    logic        was_empty;
    pkt.inst  = $urandom;
    pkt.valid = vld;
    pkt.PC    = pc;
    pkt.NPC   = pc + 32'd4;
    if_ib_packet = pkt;
    dp_pop       = pop;
    squash       = sq;
    reset        = rst;
    #1;
    check_outputs("pre");
    @(posedge clock);
    if (!rst || sq) begin
      model_q.delete();
    end else begin
      was_full  = (model_q.size() == DEPTH);
      was_empty = (model_q.size() == 0);
      if (pop && !was_empty) void'(model_q.pop_front());
      if (vld && !was_full) model_q.push_back(pkt);
    end
    #1;
    check_outputs("post");
  endtask

  task automatic push(input logic [31:0] pc);
    step(1'b1, pc, 1'b0, 1'b0, 1'b1);
  endtask

  // Pop while confirming the head PC is the one this scenario expects.
  task automatic pop_expect(input string tag, input logic [31:0] pc);
    check(tag, 128'(ib_dp_packet.PC), 128'(pc));
    step(1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
  endtask

  task automatic drain();
    while (model_q.size() != 0) step(1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
  endtask

  initial begin
    if_ib_packet = '0;
    dp_pop       = 1'b0;
    squash       = 1'b0;
    reset        = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    check("reset count", 128'(ib_count), 128'(0));
    check("reset empty", 128'(ib_empty), 128'(1));
    check("reset full",  128'(ib_full),  128'(0));
    check("reset head",  128'(ib_dp_packet), 128'(nop_pkt()));

    // First push on the first edge with reset released.
    push(32'h0);
    check("first push count", 128'(ib_count), 128'(1));
    drain();

    // Fill, overflow drop, ordered drain.
    for (int i = 0; i < 8; i++) push(32'(i * 4));
    check("fill full",  128'(ib_full),  128'(1));
    check("fill count", 128'(ib_count), 128'(8));
    push(32'h20);
    check("overflow count", 128'(ib_count), 128'(8));
    for (int i = 0; i < 8; i++) pop_expect("fill order", 32'(i * 4));
    check("fill drained", 128'(ib_empty), 128'(1));

    // Wrap-around.
    for (int i = 0; i < 6; i++) push(32'h40 + 32'(i * 4));
    for (int i = 0; i < 6; i++) pop_expect("wrap pre", 32'h40 + 32'(i * 4));
    for (int i = 0; i < 8; i++) push(32'h100 + 32'(i * 4));
    check("wrap full", 128'(ib_full), 128'(1));
    for (int i = 0; i < 8; i++) pop_expect("wrap order", 32'h100 + 32'(i * 4));

    // Push+pop while full: push dropped.
    for (int i = 0; i < 8; i++) push(32'h180 + 32'(i * 4));
    step(1'b1, 32'h200, 1'b1, 1'b0, 1'b1);
    check("full pushpop count", 128'(ib_count), 128'(7));
    for (int i = 1; i < 8; i++) pop_expect("full pushpop order", 32'h180 + 32'(i * 4));
    check("full pushpop dropped", 128'(ib_empty), 128'(1));

    // Push+pop while empty: push kept, head shows NOP until the edge.
    check("empty pushpop bubble", 128'(ib_dp_packet.inst), 128'(NOP_INST));
    step(1'b1, 32'h300, 1'b1, 1'b0, 1'b1);
    check("empty pushpop count", 128'(ib_count), 128'(1));
    check("empty pushpop pc", 128'(ib_dp_packet.PC), 128'(32'h300));
    drain();

    // Squash beats push and pop.
    for (int i = 0; i < 5; i++) push(32'h380 + 32'(i * 4));
    step(1'b1, 32'h400, 1'b1, 1'b1, 1'b1);
    check("squash count", 128'(ib_count), 128'(0));
    check("squash empty", 128'(ib_empty), 128'(1));

    // Reset mid-run beats push; first push after release lands.
    for (int i = 0; i < 3; i++) push(32'h480 + 32'(i * 4));
    step(1'b1, 32'h500, 1'b0, 1'b0, 1'b0);
    check("midreset count", 128'(ib_count), 128'(0));
    check("midreset nop", 128'(ib_dp_packet.inst), 128'(NOP_INST));
    push(32'h504);
    check("midreset repush", 128'(ib_dp_packet.PC), 128'(32'h504));

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 9) < 7), $urandom, ($urandom_range(0, 1) == 1),
           ($urandom_range(0, 99) < 3), !($urandom_range(0, 99) < 2));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
